detect_cfg_ctrl: RTL and testbench
==================================

Name: detect_cfg_ctrl

Overview:
Configuration controller for the real-time pixel sequence detector. Debounces the board push-buttons and mode switches, then stages changes to the pixel-count threshold and the filter level. Changes are committed only at a frame boundary (vsync rising edge), so the detector never runs with a threshold that changes mid-frame. Replaces the free-running per-clock threshold update in the detector datapath; the datapath consumes counter_threshold and filter_level directly.

Parameters:
DEBOUNCE_CYCLES, 500000, cycles a raw key must be stable before its debounced level changes (10 ms at 50 MHz)
THR_W, 8, threshold width
THR_DEFAULT, 30, threshold after reset or a KEY[0] command
THR_MIN, 10, lowest threshold (saturating)
THR_MAX, 95, highest threshold (saturating)
THR_STEP, 5, threshold increment/decrement
FILT_DEFAULT, 2, filter level after reset or a KEY[0] command
FILT_MAX, 7, highest filter level (lowest is 0)
REPEAT_CYCLES, 25000000, hold time per auto-repeat step (AUTO_REPEAT_EN only)

Ports:
clock  in  1  system pixel clock
reset  in  1  asynchronous, active-high
KEY  in  3  raw push-buttons, active-low: [0] restore defaults, [1] increment, [2] decrement
SW  in  3 ([8:6])  SW[8] target (0 = threshold, 1 = filter); SW[7] lock (1 = ignore commands); SW[6] staging (1 = apply immediately without waiting for vsync)
vsync  in  1  frame sync from the video pipeline, active-high
counter_threshold  out  THR_W  committed threshold to the detector
filter_level  out  3  committed filter level
cfg_update  out  1  one-cycle pulse on the cycle the outputs change
busy  out  1  high in every state except IDLE
current_state  out  3  FSM encoding, for the debug display

Behaviour:
- Reset (async) values: counter_threshold = THR_DEFAULT; filter_level = FILT_DEFAULT; cfg_update = 0; busy = 0; FSM = IDLE; debounced keys = released; staged registers = the defaults.
- Synchronisation: each KEY bit passes through a 2-flop synchroniser and then a debouncer. A command is the falling edge of a debounced key. vsync is registered once; a frame edge is that registered signal going 0 to 1.
- FSM encodings: IDLE = 0, PENDING = 1, APPLY = 2, WAIT_RELEASE = 3, REPEAT = 4 (REPEAT exists only with AUTO_REPEAT_EN).
- IDLE:
  - On a command with SW[7] = 0: compute the staged value and go to PENDING.
  - Several edges in the same cycle: priority KEY[0] > KEY[1] > KEY[2]; the lower-priority edges are discarded.
  - SW[7] = 1: commands are ignored and the FSM stays in IDLE.
- Staged value arithmetic:
  - Threshold: current ± THR_STEP, clamped to [THR_MIN, THR_MAX]. No wrap.
  - Filter: current ± 1, clamped to [0, FILT_MAX].
  - KEY[0]: restores both defaults regardless of SW[8].
  - Work in THR_W+1 bits so the subtraction cannot underflow before the clamp.
- PENDING: go to APPLY on a frame edge, or on the next cycle if SW[6] = 1. A command arriving while in PENDING is ignored.
- APPLY (one cycle): write the staged value to the outputs and pulse cfg_update; go to WAIT_RELEASE.
  - Latency: the outputs change on the clock edge that ends APPLY.
  - If the staged value equals the current value (already at a bound), still pulse cfg_update; the value is unchanged.
- WAIT_RELEASE: go to IDLE once all three debounced keys are high.
- Reset asserted in any state: immediate return to the reset values. A pending change is lost.
- vsync held high for many cycles produces only one frame edge.
- SW changes while in PENDING: the staged value already computed stands.

Optional Feature:
Macro: AUTO_REPEAT_EN.
- Defined: in WAIT_RELEASE, if KEY[1] or KEY[2] stays debounced-low for REPEAT_CYCLES, go to REPEAT. REPEAT stages one more step in the same direction and goes to PENDING, then back through APPLY and WAIT_RELEASE. The hold counter restarts on each entry to WAIT_RELEASE.
- Not defined: a held key produces exactly one step, and the REPEAT state and its counter are absent.

Decomposition:
- Shared package detect_cfg_pkg holds:
  - the FSM state localparams;
  - THR_DEFAULT, THR_MIN, THR_MAX, THR_STEP, FILT_DEFAULT, FILT_MAX, so the detector datapath uses the same limits.
- One sub-module, key_debounce: synchroniser, stability counter and debounced level. It takes DEBOUNCE_CYCLES as a parameter and is instantiated three times.

Test Plan:
All scenarios use DEBOUNCE_CYCLES = 4 and REPEAT_CYCLES = 16.
1. Reset, then check outputs: counter_threshold = 30, filter_level = 2, state = 0, cfg_update = 0. Assert reset while in PENDING: the outputs stay 30/2 and the state returns to 0.
2. SW = 000, KEY[1] pressed for 10 cycles, then a vsync pulse: threshold stays 30 until the frame edge; the cycle after APPLY shows 35 with a single cfg_update pulse. A second vsync produces no further change.
3. KEY[2] pressed four times with vsync between presses, starting from 30: 25, 20, 15, 10, and a fifth press holds 10. Pressing KEY[1] from 95 holds 95.
4. SW[8] = 1, SW[6] = 1, KEY[1] pressed: filter_level becomes 3 without any vsync, and the threshold is unchanged. KEY[0] then restores 30/2.
5. KEY[1] and KEY[2] pressed in the same cycle: the threshold increments. A glitch shorter than 4 cycles produces no command. SW[7] = 1: no state change.
6. AUTO_REPEAT_EN defined, KEY[1] held for 60 cycles with SW[6] = 1: three or more increments. AUTO_REPEAT_EN undefined, same stimulus: exactly one increment.

Source files
------------

// File: rtl/detect_cfg_pkg.sv
// detect_cfg_pkg: shared constants for the pixel sequence detector configuration.
// Holds the FSM encodings, the threshold/filter limits used by both this
// controller and the detector datapath, and the saturating step helpers.
package detect_cfg_pkg;

    localparam int THR_W = 8;

    localparam logic [THR_W-1:0] THR_DEFAULT = 8'd30;
    localparam logic [THR_W-1:0] THR_MIN     = 8'd10;
    localparam logic [THR_W-1:0] THR_MAX     = 8'd95;
    localparam logic [THR_W-1:0] THR_STEP    = 8'd5;
    localparam logic [2:0]       FILT_DEFAULT = 3'd2;
    localparam logic [2:0]       FILT_MAX     = 3'd7;

    localparam logic [2:0] ST_IDLE         = 3'd0;
    localparam logic [2:0] ST_PENDING      = 3'd1;
    localparam logic [2:0] ST_APPLY        = 3'd2;
    localparam logic [2:0] ST_WAIT_RELEASE = 3'd3;
    localparam logic [2:0] ST_REPEAT       = 3'd4;

    // One extra bit so that "current - step" shows an underflow in the MSB.
    typedef logic [THR_W:0] thr_ext_t;

    function automatic logic [THR_W-1:0] thr_step(input logic [THR_W-1:0] cur,
                                                  input logic             up);
        thr_ext_t sum_s;
        if (up) begin
            sum_s = {1'b0, cur} + {1'b0, THR_STEP};
            if (sum_s > {1'b0, THR_MAX}) begin
                sum_s = {1'b0, THR_MAX};
            end else begin
                sum_s = sum_s;
            end
        end else begin
            sum_s = {1'b0, cur} - {1'b0, THR_STEP};
            if (sum_s[THR_W] || (sum_s < {1'b0, THR_MIN})) begin
                sum_s = {1'b0, THR_MIN};
            end else begin
                sum_s = sum_s;
            end
        end
        return sum_s[THR_W-1:0];
    endfunction

    function automatic logic [2:0] filt_step(input logic [2:0] cur, input logic up);
        logic [2:0] res_s;
        if (up) begin
            res_s = (cur == FILT_MAX) ? cur : cur + 3'd1;
        end else begin
            res_s = (cur == 3'd0) ? cur : cur - 3'd1;
        end
        return res_s;
    endfunction

endpackage

// File: rtl/detect_cfg_ctrl_key_debounce.sv
// key_debounce: 2-flop synchroniser followed by a stability counter.
// The debounced level follows the synchronised key only after it has differed
// from the current level for DEBOUNCE_CYCLES consecutive cycles.
// Ports: clock, reset (async, active-high), key_raw (async input),
//        key_level (debounced level, resets to 1 = released).
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic key_raw,
    output logic key_level
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    typedef logic [CW-1:0] cnt_t;

    logic meta_q;
    logic sync_q;
    logic level_q, level_d;
    cnt_t cnt_q, cnt_d;

    // Synchroniser, counter and level registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= cnt_t'(1'b0);
        end else begin
            meta_q  <= key_raw;
            sync_q  <= meta_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    // Count how long the synchronised key has disagreed with the level.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_t'(1'b0);
        if (sync_q != level_q) begin
            if (cnt_q == cnt_t'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync_q;
            end else begin
                cnt_d = cnt_q + cnt_t'(1'b1);
            end
        end else begin
            cnt_d = cnt_t'(1'b0);
        end
    end

    assign key_level = level_q;

endmodule

// File: rtl/detect_cfg_ctrl.sv
// detect_cfg_ctrl: debounces KEY[2:0], stages threshold / filter changes and
// commits them on a vsync rising edge (or immediately when SW[6] = 1).
// Ports: clock, reset (async, active-high), KEY[2:0] (active-low buttons),
//        SW[8:6] (target / lock / immediate), vsync,
//        counter_threshold, filter_level, cfg_update (commit pulse),
//        busy (FSM not idle), current_state (FSM encoding).
// Optional feature macro: AUTO_REPEAT_EN (held KEY[1]/KEY[2] repeats steps).
module detect_cfg_ctrl
    import detect_cfg_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
`ifdef AUTO_REPEAT_EN
    , parameter int REPEAT_CYCLES = 25000000
`endif
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [2:0]       KEY,
    input  logic [8:6]       SW,
    input  logic             vsync,
    output logic [THR_W-1:0] counter_threshold,
    output logic [2:0]       filter_level,
    output logic             cfg_update,
    output logic             busy,
    output logic [2:0]       current_state
);

    logic [2:0]       key_lvl_s;
    logic [2:0]       key_prev_q;
    logic [2:0]       key_fall_s;
    logic [8:6]       sw_meta_q, sw_q;
    logic             vs_q, vs_prev_q;
    logic             frame_edge_s;
    logic [2:0]       state_q, state_d;
    logic [THR_W-1:0] thr_q, thr_d, thr_stage_q, thr_stage_d;
    logic [2:0]       filt_q, filt_d, filt_stage_q, filt_stage_d;
    logic             upd_q, upd_d;
    logic             busy_q, busy_d;
    logic             step_up_s;

`ifdef AUTO_REPEAT_EN
    localparam int RCW = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
    typedef logic [RCW-1:0] rep_cnt_t;
    rep_cnt_t rep_cnt_q, rep_cnt_d;
`endif

    genvar g;
    for (g = 0; g < 3; g++) begin : g_key
        key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clock     (clock),
            .reset     (reset),
            .key_raw   (KEY[g]),
            .key_level (key_lvl_s[g])
        );
    end

    assign key_fall_s   = key_prev_q & ~key_lvl_s;
    assign frame_edge_s = vs_q & ~vs_prev_q;
    // KEY[0] is handled separately, so the step direction only has to
    // distinguish KEY[1] (up) from KEY[2] (down).
    assign step_up_s    = key_fall_s[1];

    // State, committed outputs, staging and input conditioning registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            key_prev_q   <= 3'b111;
            sw_meta_q    <= 3'b000;
            sw_q         <= 3'b000;
            vs_q         <= 1'b0;
            vs_prev_q    <= 1'b0;
            state_q      <= ST_IDLE;
            thr_q        <= THR_DEFAULT;
            filt_q       <= FILT_DEFAULT;
            thr_stage_q  <= THR_DEFAULT;
            filt_stage_q <= FILT_DEFAULT;
            upd_q        <= 1'b0;
            busy_q       <= 1'b0;
`ifdef AUTO_REPEAT_EN
            rep_cnt_q    <= rep_cnt_t'(1'b0);
`endif
        end else begin
            key_prev_q   <= key_lvl_s;
            sw_meta_q    <= SW;
            sw_q         <= sw_meta_q;
            vs_q         <= vsync;
            vs_prev_q    <= vs_q;
            state_q      <= state_d;
            thr_q        <= thr_d;
            filt_q       <= filt_d;
            thr_stage_q  <= thr_stage_d;
            filt_stage_q <= filt_stage_d;
            upd_q        <= upd_d;
            busy_q       <= busy_d;
`ifdef AUTO_REPEAT_EN
            rep_cnt_q    <= rep_cnt_d;
`endif
        end
    end

    // Next-state, staging and commit logic.
    always_comb begin
        state_d      = state_q;
        thr_d        = thr_q;
        filt_d       = filt_q;
        thr_stage_d  = thr_stage_q;
        filt_stage_d = filt_stage_q;
        upd_d        = 1'b0;
`ifdef AUTO_REPEAT_EN
        rep_cnt_d    = rep_cnt_t'(1'b0);
`endif
        case (state_q)
            ST_IDLE: begin
                if (!sw_q[7] && (key_fall_s != 3'b000)) begin
                    state_d = ST_PENDING;
                    if (key_fall_s[0]) begin
                        thr_stage_d  = THR_DEFAULT;
                        filt_stage_d = FILT_DEFAULT;
                    end else if (sw_q[8]) begin
                        thr_stage_d  = thr_q;
                        filt_stage_d = filt_step(filt_q, step_up_s);
                    end else begin
                        thr_stage_d  = thr_step(thr_q, step_up_s);
                        filt_stage_d = filt_q;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PENDING: begin
                if (sw_q[6] || frame_edge_s) begin
                    state_d = ST_APPLY;
                end else begin
                    state_d = ST_PENDING;
                end
            end
            ST_APPLY: begin
                thr_d   = thr_stage_q;
                filt_d  = filt_stage_q;
                upd_d   = 1'b1;
                state_d = ST_WAIT_RELEASE;
            end
            ST_WAIT_RELEASE: begin
                if (&key_lvl_s) begin
                    state_d = ST_IDLE;
`ifdef AUTO_REPEAT_EN
                end else if (!key_lvl_s[1] || !key_lvl_s[2]) begin
                    if (rep_cnt_q == rep_cnt_t'(REPEAT_CYCLES - 1)) begin
                        state_d = ST_REPEAT;
                    end else begin
                        rep_cnt_d = rep_cnt_q + rep_cnt_t'(1'b1);
                        state_d   = ST_WAIT_RELEASE;
                    end
`endif
                end else begin
                    state_d = ST_WAIT_RELEASE;
                end
            end
`ifdef AUTO_REPEAT_EN
            ST_REPEAT: begin
                // Direction follows whichever step key is still held.
                state_d = ST_PENDING;
                if (sw_q[8]) begin
                    thr_stage_d  = thr_q;
                    filt_stage_d = filt_step(filt_q, !key_lvl_s[1]);
                end else begin
                    thr_stage_d  = thr_step(thr_q, !key_lvl_s[1]);
                    filt_stage_d = filt_q;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    assign counter_threshold = thr_q;
    assign filter_level      = filt_q;
    assign cfg_update        = upd_q;
    assign busy              = busy_q;
    assign current_state     = state_q;

endmodule

// File: tb/tb_detect_cfg_ctrl.sv
// Directed testbench for detect_cfg_ctrl with DEBOUNCE_CYCLES = 4 and
// REPEAT_CYCLES = 16. Inputs change and outputs are sampled on the falling edge.
module tb_detect_cfg_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] KEY   = 3'b111;
    logic [8:6] SW    = 3'b000;
    logic       vsync = 1'b0;
    logic [7:0] counter_threshold;
    logic [2:0] filter_level;
    logic       cfg_update;
    logic       busy;
    logic [2:0] current_state;

    int n_vec = 0;
    int n_err = 0;
    int upd_cnt = 0;
    int upd_snap;

    always #5 clock = ~clock;

    detect_cfg_ctrl #(
        .DEBOUNCE_CYCLES(4)
`ifdef AUTO_REPEAT_EN
        , .REPEAT_CYCLES(16)
`endif
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .KEY               (KEY),
        .SW                (SW),
        .vsync             (vsync),
        .counter_threshold (counter_threshold),
        .filter_level      (filter_level),
        .cfg_update        (cfg_update),
        .busy              (busy),
        .current_state     (current_state)
    );

    always @(negedge clock) begin
        if (cfg_update === 1'b1) upd_cnt <= upd_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Press the keys given as a low-active mask for n cycles, then release.
    task automatic press(input logic [2:0] mask, input int n);
        KEY = mask;
        tick(n);
        KEY = 3'b111;
        tick(10);
    endtask

    task automatic frame();
        vsync = 1'b1;
        tick(1);
        vsync = 1'b0;
        tick(5);
    endtask

    initial begin
        // 1. reset values, then reset while PENDING
        tick(3);
        reset = 1'b0;
        tick(2);
        chk("rst_thr", counter_threshold, 30);
        chk("rst_filt", filter_level, 2);
        chk("rst_state", current_state, 0);
        chk("rst_upd", cfg_update, 0);
        chk("rst_busy", busy, 0);
        press(3'b101, 10);
        chk("pend_state", current_state, 1);
        chk("pend_busy", busy, 1);
        reset = 1'b1;
        tick(2);
        chk("rst2_thr", counter_threshold, 30);
        chk("rst2_filt", filter_level, 2);
        chk("rst2_state", current_state, 0);
        reset = 1'b0;
        tick(3);

        // 2. increment committed only at the frame edge
        press(3'b101, 10);
        chk("inc_hold_thr", counter_threshold, 30);
        chk("inc_hold_upd", cfg_update, 0);
        upd_snap = upd_cnt;
        frame();
        chk("inc_thr", counter_threshold, 35);
        chk("inc_pulses", upd_cnt - upd_snap, 1);
        chk("inc_idle", current_state, 0);
        upd_snap = upd_cnt;
        frame();
        chk("vs2_thr", counter_threshold, 35);
        chk("vs2_pulses", upd_cnt - upd_snap, 0);

        // 3. restore, decrement to the lower bound, then climb to the upper bound
        press(3'b110, 10); frame();
        chk("def_thr", counter_threshold, 30);
        press(3'b011, 10); frame();
        chk("dec1", counter_threshold, 25);
        press(3'b011, 10); frame();
        chk("dec2", counter_threshold, 20);
        press(3'b011, 10); frame();
        chk("dec3", counter_threshold, 15);
        press(3'b011, 10); frame();
        chk("dec4", counter_threshold, 10);
        upd_snap = upd_cnt;
        press(3'b011, 10); frame();
        chk("dec_min", counter_threshold, 10);
        chk("dec_min_pulse", upd_cnt - upd_snap, 1);
        for (int i = 0; i < 17; i++) begin
            press(3'b101, 10); frame();
        end
        chk("inc_to_max", counter_threshold, 95);
        upd_snap = upd_cnt;
        press(3'b101, 10); frame();
        chk("inc_max", counter_threshold, 95);
        chk("inc_max_pulse", upd_cnt - upd_snap, 1);

        // 4. immediate filter change, then restore defaults
        SW = 3'b101;
        tick(3);
        press(3'b101, 10);
        tick(5);
        chk("filt_inc", filter_level, 3);
        chk("filt_thr", counter_threshold, 95);
        press(3'b110, 10);
        tick(5);
        chk("restore_thr", counter_threshold, 30);
        chk("restore_filt", filter_level, 2);

        // 5. simultaneous keys, short glitch, lock
        SW = 3'b000;
        tick(3);
        press(3'b001, 10); frame();
        chk("prio_thr", counter_threshold, 35);
        press(3'b101, 3);
        chk("glitch_state", current_state, 0);
        chk("glitch_busy", busy, 0);
        SW = 3'b010;
        tick(3);
        press(3'b101, 10);
        chk("lock_state", current_state, 0);
        frame();
        chk("lock_thr", counter_threshold, 35);

        // 6. held key with immediate commit
        SW = 3'b001;
        tick(3);
        upd_snap = upd_cnt;
        press(3'b101, 60);
        tick(20);
`ifdef AUTO_REPEAT_EN
        chk("hold_pulses_ge3", (upd_cnt - upd_snap) >= 3, 1);
        chk("hold_thr_ge50", counter_threshold >= 8'd50, 1);
`else
        chk("hold_pulses", upd_cnt - upd_snap, 1);
        chk("hold_thr", counter_threshold, 40);
`endif
        chk("hold_idle", current_state, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
